// File: rtl/pow_nonce_sweeper_if.sv
// pow_nonce_sweeper_if: job offer, status and SHA-256 core signals of the nonce sweeper
interface pow_nonce_sweeper_if;
  logic [0:122][7:0] job_data;
  logic [31:0]       job_nonce_start;
  logic [31:0]       job_nonce_count;
  logic [255:0]      job_target;
  logic              job_valid;
  logic              job_ready;
  logic              abort;
  logic              busy;
  logic [0:122][7:0] core_data;
  logic              core_start;
  logic              core_ready;
  logic [0:31][7:0]  core_hash;
  logic [31:0]       found_nonce;
  logic [255:0]      found_hash;
  logic              done;
  logic [1:0]        done_status;
  logic [31:0]       hash_count;
  modport master (
    input  job_data, job_nonce_start, job_nonce_count, job_target, job_valid, abort,
           core_ready, core_hash,
    output job_ready, busy, core_data, core_start, found_nonce, found_hash, done,
           done_status, hash_count
  );
  modport slave (
    output job_data, job_nonce_start, job_nonce_count, job_target, job_valid, abort,
           core_ready, core_hash,
    input  job_ready, busy, core_data, core_start, found_nonce, found_hash, done,
           done_status, hash_count
  );
endinterface

// File: rtl/pow_nonce_sweeper.sv
// pow_nonce_sweeper: feeds a nonce range through a SHA-256 core and reports the first digest below target
module pow_nonce_sweeper #(
  parameter int NONCE_OFFSET = 8
) (
  input logic clk,
  input logic rst,
  pow_nonce_sweeper_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} state_t;
  state_t state, state_nx;
  logic [1:0] status_nx;
  logic [31:0] nonce, remaining, nonce_inc;
  logic [255:0] target, hash;
  logic abort_pending, accept, hit, pend, last, advance;
  function automatic logic [0:122][7:0] put_nonce(input logic [0:122][7:0] d, input logic [31:0] n);
    put_nonce = d;
    for (int i = 0; i < 4; i++) put_nonce[NONCE_OFFSET + i] = n[31 - 8 * i -: 8];
  endfunction
  assign accept = state == IDLE && bus.job_valid;
  assign hit = hash < target;
  assign pend = abort_pending || bus.abort;
  assign last = remaining == 32'd1;
  assign advance = state == CHECK && !hit && !pend && !last;
  assign nonce_inc = nonce + 32'd1;
  assign bus.job_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.core_start = state == ISSUE;
  assign bus.done = state == FINISH;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and the completion status that accompanies entry to FINISH
  always_comb begin
    state_nx = state;
    status_nx = bus.done_status;
    case (state)
      IDLE: if (bus.job_valid) begin
        state_nx = bus.job_nonce_count == 32'd0 ? FINISH : ISSUE;
        status_nx = bus.job_nonce_count == 32'd0 ? 2'b10 : 2'b00;
      end
      ISSUE: state_nx = WAIT;
      WAIT: state_nx = bus.core_ready ? CHECK : WAIT;
      CHECK: begin
        state_nx = advance ? ISSUE : FINISH;
        status_nx = hit ? 2'b01 : pend ? 2'b11 : last ? 2'b10 : bus.done_status;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // job datapath: only the nonce bytes of the core message change between hashes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.done_status <= 2'b00;
      bus.found_nonce <= '0;
      bus.found_hash <= '0;
      bus.hash_count <= '0;
      bus.core_data <= '0;
      nonce <= '0;
      remaining <= '0;
      target <= '0;
      hash <= '0;
      abort_pending <= 1'b0;
    end else begin
      bus.done_status <= status_nx;
      abort_pending <= !accept && (abort_pending || (bus.abort && state inside {ISSUE, WAIT, CHECK}));
      if (accept) begin
        target <= bus.job_target;
        remaining <= bus.job_nonce_count;
        nonce <= bus.job_nonce_start;
        bus.hash_count <= '0;
        bus.found_nonce <= '0;
        bus.found_hash <= '0;
        bus.core_data <= put_nonce(bus.job_data, bus.job_nonce_start);
      end
      if (state == WAIT && bus.core_ready) begin
        hash <= bus.core_hash;
        bus.hash_count <= bus.hash_count + 32'd1;
      end
      if (state == CHECK && hit) begin
        bus.found_nonce <= nonce;
        bus.found_hash <= hash;
      end
      if (advance) begin
        nonce <= nonce_inc;
        remaining <= remaining - 32'd1;
        bus.core_data <= put_nonce(bus.core_data, nonce_inc);
      end
    end
endmodule

// File: tb/tb_pow_nonce_sweeper.sv
// tb_pow_nonce_sweeper: random and directed jobs against a job-level reference model and a 5-cycle core model
module tb_pow_nonce_sweeper;
  typedef logic [0:122][7:0] msg_t;
  logic clk = 1'b0;
  logic rst;
  int tests = 0, fails = 0;
  pow_nonce_sweeper_if bus();
  pow_nonce_sweeper #(.NONCE_OFFSET(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  msg_t msgs[$];
  msg_t exp_msgs[$];
  msg_t cap;
  logic [255:0] dig;
  logic [255:0] ov_dig[0:7];
  bit ov_en[0:7];
  int busy_cnt = 0, starts = 0;
  bit skip_stable = 0;
  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] digest(input msg_t m, input int k);
    logic [255:0] r;
    logic [31:0] h;
    if (k < 8 && ov_en[k]) return ov_dig[k];
    for (int w = 0; w < 8; w++) begin
      h = 32'h811c9dc5 ^ (32'(w) * 32'h9e3779b9);
      for (int b = 0; b < 123; b++) h = (h ^ {24'd0, m[b]}) * 32'h01000193;
      r[255 - 32 * w -: 32] = h;
    end
    return r;
  endfunction
  function automatic msg_t rand_msg();
    msg_t m;
    for (int i = 0; i < 123; i++) m[i] = 8'($urandom);
    return m;
  endfunction
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction
  // core model: digest delivered 5 cycles after each start pulse
  always @(negedge clk) begin
    bus.core_ready = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        bus.core_ready = 1'b1;
        bus.core_hash = dig;
        if (!skip_stable) check("core_data_stable", 1024'(bus.core_data), 1024'(cap));
      end
    end
    if (bus.core_start) begin
      check("start_while_outstanding", 1024'(busy_cnt), 1024'(0));
      cap = bus.core_data;
      dig = digest(cap, starts);
      msgs.push_back(cap);
      starts++;
      busy_cnt = 5;
    end
  end
  // job-level reference: walk the nonce range until a win, an abort or the end
  task automatic model_job(input msg_t tmpl, input logic [31:0] st, input logic [31:0] cnt,
                           input logic [255:0] tgt, input bit ab, output logic [1:0] es,
                           output logic [31:0] fn, output logic [255:0] fh, output logic [31:0] hc);
    msg_t m;
    logic [31:0] n;
    logic [255:0] d;
    exp_msgs.delete();
    es = 2'b10; fn = '0; fh = '0; hc = '0;
    for (longint k = 0; k < longint'(cnt); k++) begin
      n = st + 32'(k);
      m = tmpl;
      m[8] = n[31:24]; m[9] = n[23:16]; m[10] = n[15:8]; m[11] = n[7:0];
      exp_msgs.push_back(m);
      d = digest(m, int'(k));
      hc++;
      if (d < tgt) begin es = 2'b01; fn = n; fh = d; break; end
      if (ab) begin es = 2'b11; break; end
    end
  endtask
  task automatic run_job(input msg_t tmpl, input logic [31:0] st, input logic [31:0] cnt,
                         input logic [255:0] tgt, input bit ab, output int lat);
    logic [1:0] es;
    logic [31:0] fn, hc;
    logic [255:0] fh;
    int first;
    model_job(tmpl, st, cnt, tgt, ab, es, fn, fh, hc);
    msgs.delete();
    starts = 0;
    bus.job_data = tmpl;
    bus.job_nonce_start = st;
    bus.job_nonce_count = cnt;
    bus.job_target = tgt;
    bus.job_valid = 1'b1;
    lat = 1;
    first = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.job_valid = 1'b0;
      bus.abort = ab && first != 0 && lat == first + 2;
      if (bus.core_start && first == 0) first = lat;
    end while (!bus.done && lat < 3000);
    bus.abort = 1'b0;
    check("done_seen", 1024'(bus.done), 1024'(1));
    check("done_status", 1024'(bus.done_status), 1024'(es));
    check("found_nonce", 1024'(bus.found_nonce), 1024'(fn));
    check("found_hash", 1024'(bus.found_hash), 1024'(fh));
    check("hash_count", 1024'(bus.hash_count), 1024'(hc));
    check("start_count", 1024'(msgs.size()), 1024'(exp_msgs.size()));
    for (int i = 0; i < msgs.size() && i < exp_msgs.size(); i++)
      check($sformatf("core_msg%0d", i), 1024'(msgs[i]), 1024'(exp_msgs[i]));
    @(negedge clk);
    check("ready_after_done", 1024'(bus.job_ready), 1024'(1));
    check("done_one_cycle", 1024'(bus.done), 1024'(0));
    check("status_hold", 1024'(bus.done_status), 1024'(es));
  endtask
  task automatic check_reset_vals(input string p);
    check({p, "_job_ready"}, 1024'(bus.job_ready), 1024'(1));
    check({p, "_busy"}, 1024'(bus.busy), 1024'(0));
    check({p, "_core_start"}, 1024'(bus.core_start), 1024'(0));
    check({p, "_done"}, 1024'(bus.done), 1024'(0));
    check({p, "_status"}, 1024'(bus.done_status), 1024'(0));
    check({p, "_found_nonce"}, 1024'(bus.found_nonce), 1024'(0));
    check({p, "_found_hash"}, 1024'(bus.found_hash), 1024'(0));
    check({p, "_hash_count"}, 1024'(bus.hash_count), 1024'(0));
    check({p, "_core_data"}, 1024'(bus.core_data), 1024'(0));
  endtask
  initial begin
    int lat, k;
    logic [255:0] tgt;
    rst = 1'b1;
    bus.job_valid = 1'b0;
    bus.abort = 1'b0;
    bus.job_data = '0;
    bus.job_nonce_start = '0;
    bus.job_nonce_count = '0;
    bus.job_target = '0;
    for (int i = 0; i < 8; i++) ov_en[i] = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    run_job('0, 32'd0, 32'd4, '0, 1'b0, lat);
    run_job(rand_msg(), 32'h12345678, 32'd100, {256{1'b1}}, 1'b0, lat);
    run_job(rand_msg(), 32'hFFFFFFFF, 32'd2, '0, 1'b0, lat);
    tgt = rand256();
    tgt[255] = 1'b1;
    ov_en[0] = 1'b1; ov_dig[0] = tgt;
    ov_en[1] = 1'b1; ov_dig[1] = tgt - 256'd1;
    run_job(rand_msg(), 32'd0, 32'd5, tgt, 1'b0, lat);
    ov_en[0] = 1'b0; ov_en[1] = 1'b0;
    run_job(rand_msg(), $urandom, 32'd50, '0, 1'b1, lat);
    run_job(rand_msg(), $urandom, 32'd0, rand256(), 1'b0, lat);
    check("count0_done_latency", 1024'(lat), 1024'(2));
    skip_stable = 1;
    bus.job_data = rand_msg();
    bus.job_nonce_start = $urandom;
    bus.job_nonce_count = 32'd10;
    bus.job_target = '0;
    bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    k = 0;
    while (!bus.core_start && k < 50) begin @(negedge clk); k++; end
    check("rst_test_start_seen", 1024'(bus.core_start), 1024'(1));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midjob_reset");
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (busy_cnt != 0 && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    check("late_ready_busy", 1024'(bus.busy), 1024'(0));
    check("late_ready_hash_count", 1024'(bus.hash_count), 1024'(0));
    check("late_ready_done_status", 1024'(bus.done_status), 1024'(0));
    skip_stable = 0;
    run_job(rand_msg(), $urandom, 32'd3, {8'd40, rand256() >> 8}, 1'b0, lat);
    for (int j = 0; j < 40; j++) begin
      logic [31:0] st;
      st = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
      tgt = rand256();
      tgt[255:248] = 8'($urandom_range(0, 40));
      run_job(rand_msg(), st, 32'($urandom_range(0, 6)), tgt, $urandom_range(0, 4) == 0, lat);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
